// File: rtl/i2c_temp_target_if.sv
// I2C bus bundle for the temperature-sensor target. The open-drain SDA pad is split into the
// resolved line level (sda) and the target's pull-low enable (sda_pull); the board resolves them.
interface i2c_temp_target_if;
   logic scl;
   logic sda;
   logic sda_pull;

   modport slave  (input scl, input sda, output sda_pull);
   modport master (output scl, output sda, input sda_pull);
endinterface

// File: rtl/i2c_temp_target.sv
// ADT7420-style I2C target: pointer/data protocol, snapshot temperature regs, config reg, ID.
// Optional build macro I2C_TGT_GLITCH_FILTER_EN adds a 4-clk stability filter on SCL/SDA.
//
// state    | meaning
// IDLE     | bus free, waiting for START
// ADDR     | shifting in address + R/W
// ADDR_ACK | pulling SDA low for address ACK
// PTR      | receiving register pointer
// WDATA    | receiving write data
// W_ACK    | pulling SDA low for pointer/data ACK
// RDATA    | shifting out register byte
// R_ACK    | sampling master ACK/NACK
// IGNORE   | not addressed / NACKed, wait for START or STOP
module i2c_temp_target #(
   parameter logic [6:0] TARGET_ADDR = 7'h4B,
   parameter logic [7:0] DEVICE_ID   = 8'hCB
) (
   input  logic                    clk,
   input  logic                    rst_n,
   i2c_temp_target_if.slave        bus,
   input  logic [15:0]             temp_data,
   output logic [7:0]              cfg_reg,
   output logic                    cfg_wr,
   output logic                    busy
);

   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_ADDR     = 4'd1;
   localparam logic [3:0] S_ADDR_ACK = 4'd2;
   localparam logic [3:0] S_PTR      = 4'd3;
   localparam logic [3:0] S_WDATA    = 4'd4;
   localparam logic [3:0] S_W_ACK    = 4'd5;
   localparam logic [3:0] S_RDATA    = 4'd6;
   localparam logic [3:0] S_R_ACK    = 4'd7;
   localparam logic [3:0] S_IGNORE   = 4'd8;

   logic [1:0]  scl_sync, sda_sync;
   logic        scl_f, sda_f;
   logic        scl_q, sda_q;
   logic        scl_rise, scl_fall, start_det, stop_det;

   logic [3:0]  state;
   logic [7:0]  ptr;
   logic [15:0] snap;
   logic [7:0]  shreg;
   logic [7:0]  txreg;
   logic [2:0]  bit_cnt;
   logic        full;
   logic        rw;
   logic        mst_ack;
   logic        wr_pend;
   logic        sda_pull;
   logic [7:0]  rd_first, rd_next;

   assign bus.sda_pull = sda_pull;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync <= 2'b11;
         sda_sync <= 2'b11;
      end else begin
         scl_sync <= {scl_sync[0], bus.scl};
         sda_sync <= {sda_sync[0], bus.sda};
      end
   end

`ifdef I2C_TGT_GLITCH_FILTER_EN
   // Down-counters reload whenever the input agrees with the filtered value; the filtered
   // value only follows after four consecutive disagreeing samples.
   logic [1:0] scl_tmr, sda_tmr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_f   <= 1'b1;
         sda_f   <= 1'b1;
         scl_tmr <= 2'd3;
         sda_tmr <= 2'd3;
      end else begin
         if (scl_sync[1] == scl_f) begin
            scl_tmr <= 2'd3;
         end else if (scl_tmr == 2'd0) begin
            scl_f   <= scl_sync[1];
            scl_tmr <= 2'd3;
         end else begin
            scl_tmr <= scl_tmr - 2'd1;
         end
         if (sda_sync[1] == sda_f) begin
            sda_tmr <= 2'd3;
         end else if (sda_tmr == 2'd0) begin
            sda_f   <= sda_sync[1];
            sda_tmr <= 2'd3;
         end else begin
            sda_tmr <= sda_tmr - 2'd1;
         end
      end
   end
`else
   assign scl_f = scl_sync[1];
   assign sda_f = sda_sync[1];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_q <= 1'b1;
         sda_q <= 1'b1;
      end else begin
         scl_q <= scl_f;
         sda_q <= sda_f;
      end
   end

   assign scl_rise  = scl_f & ~scl_q;
   assign scl_fall  = ~scl_f & scl_q;
   assign start_det = scl_f & scl_q & sda_q & ~sda_f;
   assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;

   function automatic logic [7:0] reg_rd(input logic [7:0] p, input logic [15:0] s,
                                         input logic [7:0] c);
      case (p)
         8'h00:   reg_rd = s[15:8];
         8'h01:   reg_rd = s[7:0];
         8'h03:   reg_rd = c;
         8'h0B:   reg_rd = DEVICE_ID;
         default: reg_rd = 8'h00;
      endcase
   endfunction

   // First byte of a read burst comes from the live word, since the snapshot loads on that same edge.
   assign rd_first = reg_rd(ptr, temp_data, cfg_reg);
   assign rd_next  = reg_rd(ptr + 8'd1, snap, cfg_reg);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         sda_pull <= 1'b0;
         ptr      <= 8'h00;
         cfg_reg  <= 8'h00;
         snap     <= 16'h0000;
         busy     <= 1'b0;
         shreg    <= 8'h00;
         txreg    <= 8'h00;
         bit_cnt  <= 3'd7;
         full     <= 1'b0;
         rw       <= 1'b0;
         mst_ack  <= 1'b0;
         wr_pend  <= 1'b0;
      end else begin
         wr_pend <= 1'b0;
         if (start_det) begin
            state    <= S_ADDR;
            sda_pull <= 1'b0;
            busy     <= 1'b0;
            bit_cnt  <= 3'd7;
            full     <= 1'b0;
         end else if (stop_det) begin
            state    <= S_IDLE;
            sda_pull <= 1'b0;
            busy     <= 1'b0;
            bit_cnt  <= 3'd7;
            full     <= 1'b0;
         end else begin
            case (state)
               S_ADDR, S_PTR, S_WDATA: begin
                  if (scl_rise && !full) begin
                     shreg <= {shreg[6:0], sda_f};
                     if (bit_cnt == 3'd0) full <= 1'b1;
                     else bit_cnt <= bit_cnt - 3'd1;
                  end else if (scl_fall && full) begin
                     full    <= 1'b0;
                     bit_cnt <= 3'd7;
                     if (state == S_ADDR) begin
                        if (shreg[7:1] == TARGET_ADDR) begin
                           state    <= S_ADDR_ACK;
                           sda_pull <= 1'b1;
                           busy     <= 1'b1;
                           rw       <= shreg[0];
                        end else begin
                           state <= S_IGNORE;
                        end
                     end else if (state == S_PTR) begin
                        ptr      <= shreg;
                        state    <= S_W_ACK;
                        sda_pull <= 1'b1;
                     end else begin
                        if (ptr == 8'h03) begin
                           cfg_reg <= shreg;
                           wr_pend <= 1'b1;
                        end
                        ptr      <= ptr + 8'd1;
                        state    <= S_W_ACK;
                        sda_pull <= 1'b1;
                     end
                  end
               end
               S_ADDR_ACK: begin
                  if (scl_fall) begin
                     bit_cnt <= 3'd7;
                     if (rw) begin
                        snap     <= temp_data;
                        txreg    <= rd_first;
                        sda_pull <= ~rd_first[7];
                        state    <= S_RDATA;
                     end else begin
                        sda_pull <= 1'b0;
                        state    <= S_PTR;
                     end
                  end
               end
               S_W_ACK: begin
                  if (scl_fall) begin
                     sda_pull <= 1'b0;
                     bit_cnt  <= 3'd7;
                     full     <= 1'b0;
                     state    <= S_WDATA;
                  end
               end
               S_RDATA: begin
                  if (scl_fall) begin
                     if (bit_cnt == 3'd0) begin
                        sda_pull <= 1'b0;
                        mst_ack  <= 1'b0;
                        state    <= S_R_ACK;
                     end else begin
                        txreg    <= {txreg[6:0], 1'b0};
                        sda_pull <= ~txreg[6];
                        bit_cnt  <= bit_cnt - 3'd1;
                     end
                  end
               end
               S_R_ACK: begin
                  if (scl_rise) begin
                     if (sda_f) begin
                        state <= S_IGNORE;
                        busy  <= 1'b0;
                     end else begin
                        mst_ack <= 1'b1;
                     end
                  end else if (scl_fall && mst_ack) begin
                     mst_ack  <= 1'b0;
                     ptr      <= ptr + 8'd1;
                     txreg    <= rd_next;
                     sda_pull <= ~rd_next[7];
                     bit_cnt  <= 3'd7;
                     state    <= S_RDATA;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cfg_wr <= 1'b0;
      else        cfg_wr <= wr_pend;
   end

endmodule

// File: tb/tb_i2c_temp_target.sv
// Bench for i2c_temp_target: bit-banged I2C master, vector table of write/read-back
// transactions with a read scoreboard, plus hand sequences for burst, wrap, abort and reset.
module tb_i2c_temp_target;
   localparam int Q = 100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] temp_data = 16'h0000;
   logic [7:0]  cfg_reg;
   logic        cfg_wr, busy;
   logic        m_low = 1'b0;

   i2c_temp_target_if bus();
   assign bus.sda = ~(m_low | bus.sda_pull);

   always #5 clk = ~clk;

   i2c_temp_target dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .temp_data (temp_data),
      .cfg_reg   (cfg_reg),
      .cfg_wr    (cfg_wr),
      .busy      (busy)
   );

   int n_chk = 0, n_pass = 0;
   int wr_pulses = 0, wr_cycles = 0, edge_viol = 0;
   logic wr_d = 1'b0, scl_d = 1'b1, pull_d = 1'b0;
   logic mon_clr = 1'b0, pull_seen = 1'b0, busy_seen = 1'b0;
   logic [7:0] sb[$];
   logic [7:0] exp_cfg;

   always @(posedge clk) begin
      if (cfg_wr) wr_cycles++;
      if (cfg_wr && !wr_d) wr_pulses++;
      wr_d = cfg_wr;
      if (rst_n && bus.scl && scl_d && (bus.sda_pull != pull_d)) edge_viol++;
      scl_d  = bus.scl;
      pull_d = bus.sda_pull;
      if (mon_clr) begin
         pull_seen = 1'b0;
         busy_seen = 1'b0;
      end else begin
         if (bus.sda_pull) pull_seen = 1'b1;
         if (busy) busy_seen = 1'b1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", name, act, exp);
   endtask

   task automatic i2c_start();
      m_low = 1'b0; #(Q);
      bus.scl = 1'b1; #(Q);
      m_low = 1'b1; #(Q);
      bus.scl = 1'b0; #(Q);
   endtask

   task automatic i2c_stop();
      m_low = 1'b1; #(Q);
      bus.scl = 1'b1; #(Q);
      m_low = 1'b0; #(Q);
   endtask

   task automatic send_bits(input logic [7:0] b, input int n);
      for (int i = 7; i > 7 - n; i--) begin
         m_low = ~b[i]; #(Q);
         bus.scl = 1'b1; #(2*Q);
         bus.scl = 1'b0; #(Q);
      end
   endtask

   task automatic wr_byte(input logic [7:0] b, output logic ack);
      send_bits(b, 8);
      m_low = 1'b0; #(Q);
      bus.scl = 1'b1; #(Q);
      ack = bus.sda; #(Q);
      bus.scl = 1'b0; #(Q);
   endtask

   task automatic rd_byte(input logic nack, output logic [7:0] b);
      m_low = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         #(Q); bus.scl = 1'b1;
         #(Q); b[i] = bus.sda;
         #(Q); bus.scl = 1'b0;
         #(Q);
      end
      m_low = !nack; #(Q);
      bus.scl = 1'b1; #(2*Q);
      bus.scl = 1'b0; #(Q);
      m_low = 1'b0;
   endtask

   task automatic set_ptr(input logic [7:0] p);
      logic a;
      i2c_start();
      wr_byte(8'h96, a); chk("ptr_addr_ack", a, 1'b0);
      wr_byte(p, a);     chk("ptr_ack", a, 1'b0);
   endtask

   typedef struct {
      logic        do_wr;
      logic [7:0]  ptr;
      logic [7:0]  wdata;
      logic [15:0] temp;
      logic [7:0]  exp_rd;
      int          exp_pulses;
   } vec_t;

   vec_t vecs[10];

   initial begin
      logic a;
      logic [7:0] b;
      int p0;

      vecs[0] = '{1'b1, 8'h03, 8'hA5, 16'h0000, 8'hA5, 1};
      vecs[1] = '{1'b0, 8'h00, 8'h00, 16'h0C80, 8'h0C, 0};
      vecs[2] = '{1'b0, 8'h01, 8'h00, 16'h0C80, 8'h80, 0};
      vecs[3] = '{1'b0, 8'h0B, 8'h00, 16'h1111, 8'hCB, 0};
      vecs[4] = '{1'b1, 8'h0B, 8'h55, 16'h0000, 8'hCB, 0};
      vecs[5] = '{1'b1, 8'h00, 8'h12, 16'hABCD, 8'hAB, 0};
      vecs[6] = '{1'b0, 8'h02, 8'h00, 16'hFFFF, 8'h00, 0};
      vecs[7] = '{1'b1, 8'h07, 8'h33, 16'h0000, 8'h00, 0};
      vecs[8] = '{1'b1, 8'h03, 8'h5A, 16'h0000, 8'h5A, 1};
      vecs[9] = '{1'b0, 8'hFF, 8'h00, 16'h0000, 8'h00, 0};

      bus.scl = 1'b1;
      #(Q);
      chk("rst_pull", bus.sda_pull, 1'b0);
      chk("rst_cfg", cfg_reg, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_cfg_wr", cfg_wr, 1'b0);
      rst_n = 1'b1;
      #(2*Q);

      // config write
      p0 = wr_pulses;
      i2c_start();
      wr_byte(8'h96, a); chk("cw_addr_ack", a, 1'b0);
      chk("cw_busy_hi", busy, 1'b1);
      wr_byte(8'h03, a); chk("cw_ptr_ack", a, 1'b0);
      wr_byte(8'h80, a); chk("cw_data_ack", a, 1'b0);
      i2c_stop();
      #(2*Q);
      exp_cfg = 8'h80;
      chk("cw_cfg", cfg_reg, exp_cfg);
      chk("cw_pulses", wr_pulses - p0, 1);
      chk("cw_busy_lo", busy, 1'b0);

      // vector table: optional write, then pointer set + repeated-START single read
      for (int i = 0; i < 10; i++) begin
         temp_data = vecs[i].temp;
         if (vecs[i].do_wr) begin
            p0 = wr_pulses;
            set_ptr(vecs[i].ptr);
            wr_byte(vecs[i].wdata, a); chk("v_data_ack", a, 1'b0);
            i2c_stop();
            #(2*Q);
            chk("v_pulses", wr_pulses - p0, vecs[i].exp_pulses);
            if (vecs[i].exp_pulses != 0) exp_cfg = vecs[i].wdata;
         end
         set_ptr(vecs[i].ptr);
         i2c_start();
         wr_byte(8'h97, a); chk("v_rd_addr_ack", a, 1'b0);
         sb.push_back(vecs[i].exp_rd);
         rd_byte(1'b1, b);
         chk("v_rd_data", b, sb.pop_front());
         i2c_stop();
         #(Q);
      end

      // burst read: LSB must come from the snapshot even after temp_data changes
      temp_data = 16'h0C80;
      set_ptr(8'h00);
      i2c_start();
      wr_byte(8'h97, a); chk("br_addr_ack", a, 1'b0);
      sb.push_back(8'h0C);
      rd_byte(1'b0, b); chk("br_msb", b, sb.pop_front());
      temp_data = 16'hFFFF;
      sb.push_back(8'h80);
      rd_byte(1'b1, b); chk("br_lsb", b, sb.pop_front());
      chk("br_busy_nack", busy, 1'b0);
      i2c_stop();
      #(Q);

      // pointer wrap FF -> 00
      temp_data = 16'h1234;
      set_ptr(8'hFF);
      i2c_start();
      wr_byte(8'h97, a); chk("wr_addr_ack", a, 1'b0);
      sb.push_back(8'h00);
      rd_byte(1'b0, b); chk("wrap_ff", b, sb.pop_front());
      temp_data = 16'h5678;
      sb.push_back(8'h12);
      rd_byte(1'b1, b); chk("wrap_00", b, sb.pop_front());
      i2c_stop();
      #(Q);

      // wrong address
      mon_clr = 1'b1; #(Q); mon_clr = 1'b0;
      i2c_start();
      wr_byte(8'h90, a); chk("wa_nack", a, 1'b1);
      wr_byte(8'h03, a); chk("wa_byte_nack", a, 1'b1);
      wr_byte(8'h11, a);
      i2c_stop();
      #(Q);
      chk("wa_pull_seen", pull_seen, 1'b0);
      chk("wa_busy_seen", busy_seen, 1'b0);
      chk("wa_cfg", cfg_reg, exp_cfg);

      // STOP in the middle of a data byte
      set_ptr(8'h03);
      send_bits(8'h11, 4);
      i2c_stop();
      #(Q);
      chk("ab_cfg", cfg_reg, exp_cfg);
      chk("ab_busy", busy, 1'b0);
      chk("ab_pull", bus.sda_pull, 1'b0);

      // reset while the target is pulling SDA for a read-address ACK
      i2c_start();
      send_bits(8'h97, 8);
      chk("rs_pull_before", bus.sda_pull, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("rs_pull", bus.sda_pull, 1'b0);
      chk("rs_cfg", cfg_reg, 8'h00);
      chk("rs_busy", busy, 1'b0);
      chk("rs_cfg_wr", cfg_wr, 1'b0);
      exp_cfg = 8'h00;
      #(Q);
      m_low = 1'b0;
      bus.scl = 1'b1;
      #(Q);
      rst_n = 1'b1;
      #(2*Q);
      temp_data = 16'hA55A;
      i2c_start();
      wr_byte(8'h97, a); chk("rs_next_ack", a, 1'b0);
      sb.push_back(8'hA5);
      rd_byte(1'b1, b); chk("rs_ptr0_read", b, sb.pop_front());
      i2c_stop();
      #(Q);

`ifdef I2C_TGT_GLITCH_FILTER_EN
      // 2-clk low glitch on SCL during a data bit must be rejected
      set_ptr(8'h03);
      for (int i = 7; i >= 0; i--) begin
         m_low = ~b[0] & 1'b0;
         m_low = ~(8'h66 >> i) & 1'b1;
         #(Q);
         bus.scl = 1'b1; #(Q);
         if (i == 4) begin
            bus.scl = 1'b0; #20;
            bus.scl = 1'b1; #(Q-20);
         end else begin
            #(Q);
         end
         bus.scl = 1'b0; #(Q);
      end
      m_low = 1'b0; #(Q);
      bus.scl = 1'b1; #(Q);
      a = bus.sda; #(Q);
      bus.scl = 1'b0; #(Q);
      chk("gf_ack", a, 1'b0);
      i2c_stop();
      #(2*Q);
      exp_cfg = 8'h66;
      chk("gf_cfg", cfg_reg, exp_cfg);
`endif

      chk("cfg_wr_width", wr_cycles, wr_pulses);
      chk("sda_edge_viol", edge_viol, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
